// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and coordinate type shared by the VGA sync generator.
package vga_timing_pkg;
  localparam int COORD_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping axis counter: counts 0..MAX while EN is high, reloads MAX on reset.
module vga_axis_counter #(
  parameter int           W   = 10,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         CLKIN,
  input  logic         SRST,
  input  logic         EN,
  output logic [W-1:0] CNT,
  output logic [W-1:0] CNT_NXT,
  output logic         TC
);
  assign TC = (CNT == MAX);

  // CNT_NXT lets the parent decode outputs for the coordinate about to be shown
  always_comb begin
    CNT_NXT = CNT;
    if (EN) CNT_NXT = TC ? '0 : CNT + 1'b1;
  end

  always_ff @(posedge CLKIN) begin
    if (SRST) CNT <= MAX;
    else      CNT <= CNT_NXT;
  end
endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: raster counters plus registered sync, blanking and strobe outputs,
// all aligned to the coordinate presented on PIXEL_X/PIXEL_Y.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic               CLKIN,
  input  logic               SRST,
  input  logic               EN,
  output logic               HSYNC,
  output logic               VSYNC,
  output logic               ACTIVE,
  output logic [COORD_W-1:0] PIXEL_X,
  output logic [COORD_W-1:0] PIXEL_Y,
  output logic               LINE_END,
  output logic               FRAME_START,
  output logic [7:0]         FRAME_CNT
);
  localparam coord_t H_LAST   = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_LAST   = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
  localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  coord_t x_p0, y_p0, x_nxt, y_nxt;
  logic   h_tc, v_tc, frame_wrap;

  vga_axis_counter #(.W(COORD_W), .MAX(H_LAST)) u_h_cnt (
    .CLKIN   (CLKIN),
    .SRST    (SRST),
    .EN      (EN),
    .CNT     (x_p0),
    .CNT_NXT (x_nxt),
    .TC      (h_tc)
  );

  vga_axis_counter #(.W(COORD_W), .MAX(V_LAST)) u_v_cnt (
    .CLKIN   (CLKIN),
    .SRST    (SRST),
    .EN      (EN & h_tc),
    .CNT     (y_p0),
    .CNT_NXT (y_nxt),
    .TC      (v_tc)
  );

  assign PIXEL_X    = x_p0;
  assign PIXEL_Y    = y_p0;
  // Leaving the last pixel of the last line means the next coordinate is (0,0)
  assign frame_wrap = h_tc & v_tc;

  // Stage p0: decode of the next coordinate, registered alongside the counters
  always_ff @(posedge CLKIN) begin
    if (SRST) begin
      HSYNC       <= ~SYNC_POL;
      VSYNC       <= ~SYNC_POL;
      ACTIVE      <= 1'b0;
      LINE_END    <= 1'b0;
      FRAME_START <= 1'b0;
      FRAME_CNT   <= 8'd0;
    end else if (EN) begin
      HSYNC       <= in_span(x_nxt, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
      VSYNC       <= in_span(y_nxt, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
      ACTIVE      <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
      LINE_END    <= (x_nxt == H_LAST);
      FRAME_START <= frame_wrap;
      FRAME_CNT   <= FRAME_CNT + {7'd0, frame_wrap};
    end
  end
endmodule
